// File: rtl/spi_miso_tx.sv
// SPI mode-0 slave readback transmitter: snapshots rdata when chip-select falls and
// shifts it out MSB-first on miso, with sclk/cs_n oversampled in the clk domain.
module spi_miso_tx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  re,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  done,
    output logic                  abort,
    output logic [1:0]            debug_state
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_n;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_n;
    logic                  done_n, abort_n;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
    logic                   sclk_hist, cs_hist;
    logic                   sclk_s, cs_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    // cs_n synchronizer resets to the deasserted level so reset release never looks like a frame start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_hist <= sclk_s;
            cs_hist   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign cs_rise   = cs_s & ~cs_hist;
    assign cs_fall   = ~cs_s & cs_hist;

    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        shreg_n   = shreg_q;
        re        = 1'b0;
        done_n    = 1'b0;
        abort_n   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    shreg_n   = rdata;
                    re        = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // bit_cnt never reaches LAST while in SHIFT, so any cs_n rise here is an abort
                if (cs_rise) begin
                    state_n = ST_IDLE;
                    abort_n = 1'b1;
                end else if (sclk_rise) begin
                    bit_cnt_n = bit_cnt_q + CW'(1);
                    if (bit_cnt_n == LAST) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end
                end else if (sclk_fall && bit_cnt_q != '0 && bit_cnt_q < LAST) begin
                    shreg_n = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            ST_DONE: begin
                if (cs_rise) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            shreg_q   <= shreg_n;
            miso      <= (state_n == ST_SHIFT) ? shreg_n[DATA_WIDTH-1] : 1'b0;
            miso_oe   <= (state_n != ST_IDLE);
            done      <= done_n;
            abort     <= abort_n;
        end
    end

    assign debug_state = state_q;

endmodule

// File: tb/tb_spi_miso_tx.sv
// Bench for spi_miso_tx: an SPI master model drives frames, a sampler collects miso on
// sclk rises, and a monitor pops expected words from exp_q on every done pulse.
module tb_spi_miso_tx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         sclk = 1'b0;
    logic         cs_n = 1'b1;
    logic [W-1:0] rdata = '0;
    logic         re, miso, miso_oe, done, abort;
    logic [1:0]   debug_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_word = '0;
    int           tests = 0;
    int           failed = 0;
    int           re_cnt = 0, done_cnt = 0, abort_cnt = 0;
    int           re0, done0, abort0;

    spi_miso_tx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .sclk(sclk), .cs_n(cs_n), .rdata(rdata),
        .re(re), .miso(miso), .miso_oe(miso_oe), .done(done), .abort(abort),
        .debug_state(debug_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // master-side sampler: the master reads miso on every sclk rise
    always @(negedge cs_n) rx_word = '0;
    always @(posedge sclk) begin
        if (rstn && !cs_n) begin
            rx_word = {rx_word[W-2:0], miso};
            check("miso_oe_during_frame", {31'd0, miso_oe}, 32'd1);
        end
    end

    // monitor: counts pulses and scores every completed frame
    always @(negedge clk) begin
        if (re || done || abort)
            check("pulse_exclusive", {29'd0, re, done, abort} & ({29'd0, re, done, abort} - 32'd1), 32'd0);
        if (re) re_cnt++;
        if (abort) abort_cnt++;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
            else check("frame_word", {16'd0, rx_word}, {16'd0, exp_q.pop_front()});
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap_counts();
        re0 = re_cnt; done0 = done_cnt; abort0 = abort_cnt;
    endtask

    task automatic start_frame(input logic [W-1:0] data);
        rdata = data;
        cs_n  = 1'b0;
        idle(6);
    endtask

    task automatic sclk_pulse();
        sclk = 1'b1;
        idle(5);
        sclk = 1'b0;
        idle(5);
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        idle(6);
    endtask

    task automatic full_frame(input logic [W-1:0] data);
        exp_q.push_back(data);
        start_frame(data);
        repeat (W) sclk_pulse();
        end_frame();
    endtask

    initial begin
        // reset state
        idle(3);
        check("reset_miso",    {31'd0, miso},    32'd0);
        check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("reset_pulses",  {29'd0, re, done, abort}, 32'd0);
        check("reset_state",   {30'd0, debug_state}, 32'd0);
        rstn = 1'b1;
        idle(4);

        // nominal frame
        snap_counts();
        exp_q.push_back(16'hA5C3);
        start_frame(16'hA5C3);
        check("nom_re_once",     re_cnt - re0, 1);
        check("nom_first_bit",   {31'd0, miso},    32'd1);
        check("nom_oe_capture",  {31'd0, miso_oe}, 32'd1);
        repeat (W) sclk_pulse();
        check("nom_oe_in_done",  {31'd0, miso_oe}, 32'd1);
        check("nom_miso_in_done", {31'd0, miso},   32'd0);
        end_frame();
        check("nom_oe_after",    {31'd0, miso_oe}, 32'd0);
        check("nom_done_once",   done_cnt - done0, 1);
        check("nom_no_abort",    abort_cnt - abort0, 0);

        // snapshot isolation
        exp_q.push_back(16'hFFFF);
        start_frame(16'hFFFF);
        repeat (3) sclk_pulse();
        rdata = 16'h1234;
        repeat (W - 3) sclk_pulse();
        end_frame();
        full_frame(16'h1234);

        // abort after 7 bits
        snap_counts();
        start_frame(16'hA5C3);
        repeat (7) sclk_pulse();
        cs_n = 1'b1;
        idle(4);
        check("abort_oe_off",   {31'd0, miso_oe}, 32'd0);
        check("abort_miso_off", {31'd0, miso},    32'd0);
        idle(4);
        check("abort_once",     abort_cnt - abort0, 1);
        check("abort_no_done",  done_cnt - done0, 0);

        // over-clocking: 20 sclk pulses
        snap_counts();
        exp_q.push_back(16'h8001);
        start_frame(16'h8001);
        repeat (W + 4) sclk_pulse();
        check("over_extra_bits", {28'd0, rx_word[3:0]}, 32'd0);
        end_frame();
        check("over_done_once", done_cnt - done0, 1);
        check("over_re_once",   re_cnt - re0, 1);

        // async reset mid-frame
        snap_counts();
        start_frame(16'hBEEF);
        repeat (5) sclk_pulse();
        rstn = 1'b0;
        #1;
        check("rst_miso",    {31'd0, miso},    32'd0);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_pulses",  {29'd0, re, done, abort}, 32'd0);
        cs_n = 1'b1;
        idle(2);
        rstn = 1'b1;
        idle(4);
        full_frame(16'h00FF);
        check("rst_no_abort", abort_cnt - abort0, 0);
        check("rst_done_new_only", done_cnt - done0, 1);

        // back-to-back with a 4-cycle cs_n gap
        snap_counts();
        exp_q.push_back(16'h0F0F);
        start_frame(16'h0F0F);
        repeat (W) sclk_pulse();
        cs_n = 1'b1;
        idle(4);
        exp_q.push_back(16'h5555);
        start_frame(16'h5555);
        repeat (W) sclk_pulse();
        end_frame();
        check("b2b_re_twice",   re_cnt - re0, 2);
        check("b2b_done_twice", done_cnt - done0, 2);

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
